// File: rtl/afg_pkg.sv
// Shared game-level codes, boss FSM states and counter sizing.
package afg_pkg;

    localparam logic [5:0] LVL_START = 6'b000001;
    localparam logic [5:0] LVL_BOSS  = 6'b001000;

    // Wide enough for the flash and dying frame counts.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_FLASH  = 3'd2,
        ST_DYING  = 3'd3,
        ST_DEAD   = 3'd4
    } boss_state_e;

endpackage

// File: rtl/boss_hitbox.sv
// Combinational hitbox test: bullet inside the boss rectangle, edges inclusive.
module boss_hitbox (
    input  logic [9:0] boss_x,
    input  logic [9:0] boss_y,
    input  logic [9:0] bullet_x,
    input  logic [9:0] bullet_y,
    input  logic [9:0] half_w,
    input  logic [9:0] half_h,
    output logic       hit
);

    // 11-bit sums so that position + half-extent cannot wrap.
    logic [10:0] bullet_x_ext;
    logic [10:0] bullet_y_ext;
    logic [10:0] boss_x_ext;
    logic [10:0] boss_y_ext;

    assign bullet_x_ext = {1'b0, bullet_x} + {1'b0, half_w};
    assign bullet_y_ext = {1'b0, bullet_y} + {1'b0, half_h};
    assign boss_x_ext   = {1'b0, boss_x} + {1'b0, half_w};
    assign boss_y_ext   = {1'b0, boss_y} + {1'b0, half_h};

    assign hit = (bullet_x_ext >= {1'b0, boss_x}) &&
                 ({1'b0, bullet_x} <= boss_x_ext) &&
                 (bullet_y_ext >= {1'b0, boss_y}) &&
                 ({1'b0, bullet_y} <= boss_y_ext);

endmodule

// File: rtl/boss_health.sv
// Boss health / hit FSM: takes bullet hits, runs the post-hit invulnerability
// flash and the death animation, and produces registered status and pulses.
module boss_health
    import afg_pkg::*;
#(
    parameter logic [9:0] BOSS_HALF_W  = 10'd60,
    parameter logic [9:0] BOSS_HALF_H  = 10'd45,
    parameter logic [3:0] BOSS_MAX_HP  = 4'd15,
    parameter int         FLASH_FRAMES = 8,
    parameter int         DYING_FRAMES = 32
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [5:0] level,
    input  logic [9:0] BossX,
    input  logic [9:0] BossY,
    input  logic [9:0] BulletX,
    input  logic [9:0] BulletY,
    input  logic       bullet_valid,
    output logic       bullet_ack,
    output logic [3:0] boss_hp,
    output logic       boss_alive,
    output logic       boss_flash,
    output logic       boss_dying,
    output logic       score_inc,
    output logic       boss_defeated
);

    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] DYING_LOAD = CNT_W'(DYING_FRAMES - 1);

    boss_state_e      state_q, state_d;
    logic [3:0]       hp_q, hp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             score_q, score_d;
    logic             defeated_q, defeated_d;
    logic             alive_q, alive_d;
    logic             flash_q, flash_d;
    logic             dying_q, dying_d;
    logic             box_hit;
    logic             hit;

    boss_hitbox u_hitbox (
        .boss_x   (BossX),
        .boss_y   (BossY),
        .bullet_x (BulletX),
        .bullet_y (BulletY),
        .half_w   (BOSS_HALF_W),
        .half_h   (BOSS_HALF_H),
        .hit      (box_hit)
    );

    assign hit = bullet_valid && box_hit;

    // Next-state, health, counter and pulse logic; start screen overrides all,
    // non-boss levels freeze everything.
    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        score_d    = 1'b0;
        defeated_d = 1'b0;
        if (level == LVL_START) begin
            state_d = ST_IDLE;
            hp_d    = BOSS_MAX_HP;
            cnt_d   = '0;
        end else if (level == LVL_BOSS) begin
            case (state_q)
                ST_IDLE: state_d = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (hit) begin
                        ack_d   = 1'b1;
                        score_d = 1'b1;
                        if (hp_q > 4'd1) begin
                            hp_d    = hp_q - 4'd1;
                            cnt_d   = FLASH_LOAD;
                            state_d = ST_FLASH;
                        end else begin
                            hp_d    = 4'd0;
                            cnt_d   = DYING_LOAD;
                            state_d = ST_DYING;
                        end
                    end
                end
                ST_FLASH: begin
                    if (cnt_q == '0) state_d = ST_ACTIVE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_DYING: begin
                    if (cnt_q == '0) begin
                        state_d    = ST_DEAD;
                        defeated_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DEAD: state_d = ST_DEAD;
                default: state_d = ST_IDLE;
            endcase
        end
        alive_d = (state_d == ST_ACTIVE) || (state_d == ST_FLASH);
        flash_d = (state_d == ST_FLASH);
        dying_d = (state_d == ST_DYING);
    end

    // State, health, counter and registered outputs with async active-low reset.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            hp_q       <= BOSS_MAX_HP;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            score_q    <= 1'b0;
            defeated_q <= 1'b0;
            alive_q    <= 1'b0;
            flash_q    <= 1'b0;
            dying_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            score_q    <= score_d;
            defeated_q <= defeated_d;
            alive_q    <= alive_d;
            flash_q    <= flash_d;
            dying_q    <= dying_d;
        end
    end

    assign bullet_ack    = ack_q;
    assign score_inc     = score_q;
    assign boss_defeated = defeated_q;
    assign boss_hp       = hp_q;
    assign boss_alive    = alive_q;
    assign boss_flash    = flash_q;
    assign boss_dying    = dying_q;

endmodule

// File: tb/tb_boss_health.sv
// Self-checking bench for boss_health: directed table, hand-written corner
// sequences, and randomized stimulus against a frame-level reference model.
module tb_boss_health;

    localparam logic [5:0] L_START = 6'b000001;
    localparam logic [5:0] L_BOSS  = 6'b001000;
    localparam logic [5:0] L_OTHER = 6'b000100;
    localparam int HW = 60, HH = 45, MAX_HP = 15, FLASH_N = 8, DYING_N = 32;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [5:0] level;
    logic [9:0] BossX, BossY, BulletX, BulletY;
    logic       bullet_valid;
    logic       bullet_ack, boss_alive, boss_flash, boss_dying, score_inc, boss_defeated;
    logic [3:0] boss_hp;

    always #5 frame_clk = ~frame_clk;

    boss_health dut (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .level         (level),
        .BossX         (BossX),
        .BossY         (BossY),
        .BulletX       (BulletX),
        .BulletY       (BulletY),
        .bullet_valid  (bullet_valid),
        .bullet_ack    (bullet_ack),
        .boss_hp       (boss_hp),
        .boss_alive    (boss_alive),
        .boss_flash    (boss_flash),
        .boss_dying    (boss_dying),
        .score_inc     (score_inc),
        .boss_defeated (boss_defeated)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: frames left in flash / dying, armed and dead flags.
    int m_hp, m_flash_left, m_dying_left;
    bit m_armed, m_dead, m_ack, m_def;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit model_hit();
        int bx = int'(BossX), by = int'(BossY), x = int'(BulletX), y = int'(BulletY);
        return bullet_valid && (x >= bx - HW) && (x <= bx + HW) &&
               (y >= by - HH) && (y <= by + HH);
    endfunction

    task automatic model_reset();
        m_hp = MAX_HP; m_flash_left = 0; m_dying_left = 0;
        m_armed = 0; m_dead = 0; m_ack = 0; m_def = 0;
    endtask

    task automatic model_step();
        bit h;
        h = model_hit();
        m_ack = 0; m_def = 0;
        if (level == L_START) begin
            model_reset();
        end else if (level == L_BOSS) begin
            if (!m_armed) m_armed = 1;
            else if (m_dead) ;
            else if (m_dying_left > 0) begin
                m_dying_left--;
                if (m_dying_left == 0) begin m_dead = 1; m_def = 1; end
            end else if (m_flash_left > 0) m_flash_left--;
            else if (h) begin
                m_ack = 1;
                if (m_hp > 1) begin m_hp--; m_flash_left = FLASH_N; end
                else begin m_hp = 0; m_dying_left = DYING_N; end
            end
        end
    endtask

    task automatic check_model();
        check("bullet_ack", bullet_ack, m_ack);
        check("score_inc", score_inc, m_ack);
        check("boss_hp", boss_hp, m_hp);
        check("boss_alive", boss_alive, m_armed && !m_dead && m_dying_left == 0);
        check("boss_flash", boss_flash, m_flash_left > 0);
        check("boss_dying", boss_dying, m_dying_left > 0);
        check("boss_defeated", boss_defeated, m_def);
    endtask

    task automatic step();
        @(posedge frame_clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_bullet(input int x, input int y, input logic v);
        BulletX = 10'(x); BulletY = 10'(y); bullet_valid = v;
    endtask

    task automatic do_reset();
        @(negedge frame_clk);
        Reset_n = 1'b0; level = 6'b0; bullet_valid = 1'b0;
        model_reset();
        #1;
        check_model();
        @(negedge frame_clk);
        Reset_n = 1'b1;
    endtask

    // Arm the boss and land 15 spaced hits; leaves the boss in its first dying frame.
    task automatic kill_to_dying();
        level = L_BOSS; set_bullet(0, 0, 0);
        step();
        for (int k = 0; k < MAX_HP; k++) begin
            set_bullet(320, 100, 1);
            step();
            set_bullet(320, 100, 0);
            for (int t = 0; t < 20 && boss_flash; t++) step();
        end
    endtask

    typedef struct {
        logic [5:0] lvl;
        int         x, y;
        logic       v;
        int         e_ack, e_hp, e_alive, e_flash;
    } vec_t;

    vec_t tbl[6];
    int fc, dc, defc, ackc, frz_ok;

    initial begin
        tbl[0] = '{L_BOSS, 0,   0,   0, 0, 15, 1, 0};  // arm
        tbl[1] = '{L_BOSS, 381, 100, 1, 0, 15, 1, 0};  // just past right edge
        tbl[2] = '{L_BOSS, 380, 145, 1, 1, 14, 1, 1};  // bottom-right corner hit
        tbl[3] = '{L_BOSS, 380, 145, 1, 0, 14, 1, 1};  // invulnerable
        tbl[4] = '{L_BOSS, 260, 55,  1, 0, 14, 1, 1};  // invulnerable
        tbl[5] = '{L_OTHER, 320, 100, 1, 0, 14, 1, 1}; // frozen

        Reset_n = 1'b0; level = 6'b0;
        BossX = 10'd320; BossY = 10'd100;
        set_bullet(0, 0, 0);
        model_reset();

        // Directed table
        do_reset();
        check("reset_hp", boss_hp, 15);
        for (int i = 0; i < 6; i++) begin
            level = tbl[i].lvl;
            set_bullet(tbl[i].x, tbl[i].y, tbl[i].v);
            step();
            check($sformatf("tbl%0d_ack", i), bullet_ack, tbl[i].e_ack);
            check($sformatf("tbl%0d_hp", i), boss_hp, tbl[i].e_hp);
            check($sformatf("tbl%0d_alive", i), boss_alive, tbl[i].e_alive);
            check($sformatf("tbl%0d_flash", i), boss_flash, tbl[i].e_flash);
        end

        // Flash length and top-left corner hit
        do_reset();
        level = L_BOSS; step();
        set_bullet(260, 55, 1); step();
        set_bullet(0, 0, 0);
        check("corner_hit_ack", bullet_ack, 1);
        fc = boss_flash ? 1 : 0;
        for (int t = 0; t < 20 && boss_flash; t++) begin
            step();
            if (boss_flash) fc++;
        end
        check("flash_frames", fc, 8);

        // Continuous hitting bullet: one decrement every 9 frames
        do_reset();
        level = L_BOSS; step();
        set_bullet(330, 110, 1);
        ackc = 0;
        for (int t = 0; t < 36; t++) begin
            step();
            if (bullet_ack) ackc++;
        end
        check("hold_acks", ackc, 4);
        check("hold_hp", boss_hp, 11);

        // Kill sequence, dying length, single defeated pulse, DEAD holds
        do_reset();
        kill_to_dying();
        check("kill_hp", boss_hp, 0);
        check("kill_dying", boss_dying, 1);
        dc = 1; defc = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (boss_dying) dc++;
            if (boss_defeated) defc++;
            if (!boss_dying) break;
        end
        check("dying_frames", dc, 32);
        check("defeated_pulses", defc, 1);
        set_bullet(320, 100, 1);
        ackc = 0; defc = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (bullet_ack || boss_alive || boss_dying) ackc++;
            if (boss_defeated) defc++;
        end
        check("dead_quiet", ackc, 0);
        check("dead_no_repulse", defc, 0);

        // Start screen beats a simultaneous hit
        do_reset();
        level = L_BOSS; set_bullet(320, 100, 0); step();
        level = L_START; set_bullet(320, 100, 1); step();
        check("prio_ack", bullet_ack, 0);
        check("prio_hp", boss_hp, 15);
        check("prio_alive", boss_alive, 0);

        // Freeze mid-flash, then resume
        level = L_BOSS; set_bullet(0, 0, 0); step();
        set_bullet(320, 100, 1); step();
        set_bullet(0, 0, 0);
        fc = 1;
        for (int t = 0; t < 2; t++) begin step(); if (boss_flash) fc++; end
        level = L_OTHER; set_bullet(320, 100, 1);
        frz_ok = 0;
        for (int t = 0; t < 5; t++) begin
            step();
            if (boss_flash && !bullet_ack && boss_hp == 4'd14) frz_ok++;
        end
        check("freeze_hold", frz_ok, 5);
        level = L_BOSS; set_bullet(0, 0, 0);
        for (int t = 0; t < 20 && boss_flash; t++) begin
            step();
            if (boss_flash) fc++;
        end
        check("freeze_flash_total", fc, 8);

        // Reset in the middle of dying: no defeated pulse afterwards
        do_reset();
        kill_to_dying();
        for (int t = 0; t < 10; t++) step();
        do_reset();
        check("mid_dying_reset_dying", boss_dying, 0);
        level = L_BOSS; set_bullet(0, 0, 0);
        defc = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (boss_defeated) defc++;
        end
        check("mid_dying_no_defeat", defc, 0);
        check("mid_dying_hp", boss_hp, 15);

        // Randomized play against the model
        do_reset();
        for (int t = 0; t < 600; t++) begin
            int r;
            r = int'($urandom_range(0, 99));
            level = (r < 3) ? L_START : (r < 12) ? L_OTHER : L_BOSS;
            if ($urandom_range(0, 49) == 0) begin
                BossX = 10'($urandom_range(70, 900));
                BossY = 10'($urandom_range(50, 900));
            end
            set_bullet(int'(BossX) + int'($urandom_range(0, 140)) - 70,
                       int'(BossY) + int'($urandom_range(0, 110)) - 55,
                       ($urandom_range(0, 9) < 7));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
